// File: rtl/quad_knob_emulator_if.sv
// Command channel of the quadrature encoder emulator.
//   cmd_valid  - command offered by the master
//   cmd_ready  - emulator is idle and will take the command on this edge
//   cmd_dir    - 0 = right (clockwise) click, 1 = left click
//   cmd_clicks - number of clicks, 0..255
//   cmd_press  - issue a press after the clicks
interface quad_knob_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_clicks;
    logic       cmd_press;

    modport master (output cmd_valid, cmd_dir, cmd_clicks, cmd_press, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_clicks, cmd_press, output cmd_ready);
endinterface

// File: rtl/quad_knob_emulator.sv
// Rotary push-encoder emulator: drives rot_A/rot_B/rot_dwn exactly like the
// physical encoder, under command control, with optional contact bounce.
// Ports:
//   clk      - system clock, all logic on posedge
//   reset    - asynchronous, active-low reset
//   cmd      - command channel (valid/ready, dir, clicks, press)
//   rot_A    - quadrature A (registered)
//   rot_B    - quadrature B (registered)
//   rot_dwn  - push button (registered)
//   busy     - high while a command is in progress
//   done     - one-cycle pulse when a command completes
//   position - signed click count, +1 right / -1 left, wraps mod 256
module quad_knob_emulator #(
    parameter int PHASE_CYC  = 4,
    parameter int DETENT_CYC = 8,
    parameter int PRESS_CYC  = 16,
    parameter int BOUNCE_N   = 0
) (
    input  logic                clk,
    input  logic                reset,
    quad_knob_emulator_if.slave cmd,
    output logic                rot_A,
    output logic                rot_B,
    output logic                rot_dwn,
    output logic                busy,
    output logic                done,
    output logic signed [7:0]   position
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] DETENT_LAST = CNT_W'(DETENT_CYC - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST  = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_N > 0) ? BOUNCE_N - 1 : 0);

    typedef enum logic [2:0] {IDLE, STEP, BOUNCE, DWELL, PRESS, FINISH} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        clicks_q, clicks_d;
    logic              dir_q, dir_d;
    logic              press_q, press_d;
    logic [1:0]        ab_q, ab_d;
    logic              dwn_q, dwn_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic signed [7:0] pos_q, pos_d;
    logic              launch;
    logic [1:0]        launch_idx;
    logic              launch_dir;

    // {A,B} for quadrature phase idx (0..3) of one click; phase 3 is the detent.
    function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] idx);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = dir ? 2'b10 : 2'b01;
            2'd1:    ab = 2'b00;
            2'd2:    ab = dir ? 2'b01 : 2'b10;
            default: ab = 2'b11;
        endcase
        return ab;
    endfunction

    function automatic logic [1:0] prev_ab(input logic dir, input logic [1:0] idx);
        return (idx == 2'd0) ? 2'b11 : phase_ab(dir, idx - 2'd1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        clicks_d   = clicks_q;
        dir_d      = dir_q;
        press_d    = press_q;
        ab_d       = ab_q;
        dwn_d      = dwn_q;
        pos_d      = pos_q;
        launch     = 1'b0;
        launch_idx = 2'd0;
        launch_dir = dir_q;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d    = cmd.cmd_dir;
                    clicks_d = cmd.cmd_clicks;
                    press_d  = cmd.cmd_press;
                    cnt_d    = '0;
                    if (cmd.cmd_clicks != 8'd0) begin
                        // Direction is not latched yet, so launch from the command itself.
                        launch     = 1'b1;
                        launch_dir = cmd.cmd_dir;
                    end else if (cmd.cmd_press) begin
                        state_d = PRESS;
                        dwn_d   = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            BOUNCE: begin
                // Odd bounce cycles revert the changing line; only one line differs
                // between consecutive phases, so the previous phase value is the glitch.
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = STEP;
                    cnt_d   = '0;
                    ab_d    = phase_ab(dir_q, phase_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    ab_d  = cnt_d[0] ? prev_ab(dir_q, phase_q) : phase_ab(dir_q, phase_q);
                end
            end
            STEP: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d = '0;
                    if (phase_q != 2'd3) begin
                        launch     = 1'b1;
                        launch_idx = phase_q + 2'd1;
                    end else begin
                        clicks_d = clicks_q - 8'd1;
                        if (clicks_q > 8'd1) begin
                            state_d = DWELL;
                        end else if (press_q) begin
                            state_d = PRESS;
                            dwn_d   = 1'b1;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DWELL: begin
                if (cnt_q == DETENT_LAST) begin
                    launch = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    dwn_d   = 1'b0;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Start of a quadrature phase: exactly one line changes on this edge.
        if (launch) begin
            phase_d = launch_idx;
            ab_d    = phase_ab(launch_dir, launch_idx);
            cnt_d   = '0;
            state_d = (BOUNCE_N > 0) ? BOUNCE : STEP;
            if (launch_idx == 2'd3) begin
                pos_d = pos_q + (launch_dir ? -8'sd1 : 8'sd1);
            end
        end

        ready_d = (state_d == IDLE);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ab_q    <= 2'b11;
            dwn_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            dwn_q   <= dwn_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            pos_q   <= pos_d;
        end
    end

    // Command/sequencing data is always reloaded on accept or phase launch before use.
    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        phase_q  <= phase_d;
        clicks_q <= clicks_d;
        dir_q    <= dir_d;
        press_q  <= press_d;
    end

    assign rot_A         = ab_q[1];
    assign rot_B         = ab_q[0];
    assign rot_dwn       = dwn_q;
    assign done          = done_q;
    assign busy          = ~ready_q;
    assign cmd.cmd_ready = ready_q;
    assign position      = pos_q;
endmodule

// File: tb/tb_quad_knob_emulator.sv
module tb_quad_knob_emulator;
    localparam int PHASE_CYC  = 4;
    localparam int DETENT_CYC = 8;
    localparam int PRESS_CYC  = 16;
    localparam int BN1        = 2;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       dwn;
        logic       done;
        logic       busy;
        logic       ready;
        logic [7:0] pos;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rot_a, rot_b, rot_dwn, busy_w, done_w;
    logic [7:0] pos0, pos1;

    int         vectors;
    int         miscompares;
    vec_t       exp_q[$];
    logic [7:0] model_pos[2];

    bit [1:0]   a_s1, b_s1, a_db, b_db, a_dbd;
    int         right_cnt[2];
    int         left_cnt[2];

    always #5 clk = ~clk;

    quad_knob_emulator_if cmd0 ();
    quad_knob_emulator_if cmd1 ();

    quad_knob_emulator #(.PHASE_CYC(PHASE_CYC), .DETENT_CYC(DETENT_CYC),
                         .PRESS_CYC(PRESS_CYC), .BOUNCE_N(0)) dut0 (
        .clk(clk), .reset(reset), .cmd(cmd0),
        .rot_A(rot_a[0]), .rot_B(rot_b[0]), .rot_dwn(rot_dwn[0]),
        .busy(busy_w[0]), .done(done_w[0]), .position(pos0));

    quad_knob_emulator #(.PHASE_CYC(PHASE_CYC), .DETENT_CYC(DETENT_CYC),
                         .PRESS_CYC(PRESS_CYC), .BOUNCE_N(BN1)) dut1 (
        .clk(clk), .reset(reset), .cmd(cmd1),
        .rot_A(rot_a[1]), .rot_B(rot_b[1]), .rot_dwn(rot_dwn[1]),
        .busy(busy_w[1]), .done(done_w[1]), .position(pos1));

    // Quadrature decoder model: 2-sample debounce on A and B, count on rising edge of
    // debounced A; B low means a right click, B high a left click.
    always @(negedge clk) begin
        if (!reset) begin
            a_s1  <= 2'b11;
            b_s1  <= 2'b11;
            a_db  <= 2'b11;
            b_db  <= 2'b11;
            a_dbd <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rot_a[i] == a_s1[i]) a_db[i] <= rot_a[i];
                if (rot_b[i] == b_s1[i]) b_db[i] <= rot_b[i];
                if (a_db[i] && !a_dbd[i]) begin
                    if (b_db[i]) left_cnt[i]  <= left_cnt[i] + 1;
                    else         right_cnt[i] <= right_cnt[i] + 1;
                end
            end
            a_s1  <= rot_a;
            b_s1  <= rot_b;
            a_dbd <= a_db;
        end
    end

    function automatic vec_t observe(input int inst);
        vec_t v;
        if (inst == 0) begin
            v.a = rot_a[0]; v.b = rot_b[0]; v.dwn = rot_dwn[0]; v.done = done_w[0];
            v.busy = busy_w[0]; v.ready = cmd0.cmd_ready; v.pos = pos0;
        end else begin
            v.a = rot_a[1]; v.b = rot_b[1]; v.dwn = rot_dwn[1]; v.done = done_w[1];
            v.busy = busy_w[1]; v.ready = cmd1.cmd_ready; v.pos = pos1;
        end
        return v;
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("A=%b B=%b dwn=%b done=%b busy=%b ready=%b pos=%h",
                         v.a, v.b, v.dwn, v.done, v.busy, v.ready, v.pos);
    endfunction

    function automatic vec_t mk(input logic [1:0] ab, input logic dwn, input logic dn,
                                input logic [7:0] pos);
        vec_t v;
        v.a = ab[1]; v.b = ab[0]; v.dwn = dwn; v.done = dn;
        v.busy = 1'b1; v.ready = 1'b0; v.pos = pos;
        return v;
    endfunction

    function automatic vec_t idle_vec(input logic [7:0] pos);
        vec_t v;
        v.a = 1'b1; v.b = 1'b1; v.dwn = 1'b0; v.done = 1'b0;
        v.busy = 1'b0; v.ready = 1'b1; v.pos = pos;
        return v;
    endfunction

    // Pushes the expected per-cycle pin trace, starting the cycle after accept
    // and ending with the done cycle; returns the final position.
    function automatic logic [7:0] build_trace(input int bn, input logic dir, input int n,
                                               input logic press, input logic [7:0] pos_in);
        logic [7:0] pos;
        logic [1:0] seq[4];
        logic [1:0] prev;
        logic [1:0] nw;
        pos = pos_in;
        if (dir) begin
            seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b11;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b11;
        end
        for (int i = 0; i < n; i++) begin
            prev = 2'b11;
            for (int ph = 0; ph < 4; ph++) begin
                nw = seq[ph];
                if (ph == 3) pos = dir ? pos - 8'd1 : pos + 8'd1;
                for (int k = 0; k < bn; k++)
                    exp_q.push_back(mk(((k % 2) == 0) ? nw : prev, 1'b0, 1'b0, pos));
                for (int k = 0; k < PHASE_CYC; k++)
                    exp_q.push_back(mk(nw, 1'b0, 1'b0, pos));
                prev = nw;
            end
            if (i < n - 1)
                for (int k = 0; k < DETENT_CYC; k++)
                    exp_q.push_back(mk(2'b11, 1'b0, 1'b0, pos));
        end
        if (press)
            for (int k = 0; k < PRESS_CYC; k++)
                exp_q.push_back(mk(2'b11, 1'b1, 1'b0, pos));
        exp_q.push_back(mk(2'b11, 1'b0, 1'b1, pos));
        return pos;
    endfunction

    task automatic drive(input int inst, input logic v, input logic dir,
                         input logic [7:0] n, input logic p);
        if (inst == 0) begin
            cmd0.cmd_valid = v; cmd0.cmd_dir = dir; cmd0.cmd_clicks = n; cmd0.cmd_press = p;
        end else begin
            cmd1.cmd_valid = v; cmd1.cmd_dir = dir; cmd1.cmd_clicks = n; cmd1.cmd_press = p;
        end
    endtask

    // Entered at the negedge of the first cycle after accept.
    task automatic check_trace(input int inst, input string name);
        vec_t got, exp;
        int   cyc;
        cyc = 1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = observe(inst);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d after accept: got %s, expected %s",
                         name, cyc, fmt(got), fmt(exp));
            end
            cyc++;
            @(negedge clk);
        end
        exp = idle_vec(model_pos[inst]);
        got = observe(inst);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s idle after done: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic run_cmd(input int inst, input logic dir, input logic [7:0] n,
                           input logic press, input logic hold, input string name);
        vec_t got;
        int   guard;
        drive(inst, 1'b1, dir, n, press);
        guard = 0;
        got = observe(inst);
        while (got.ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
            got = observe(inst);
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL %s accept timeout: cmd_ready=%b, required 1", name, got.ready);
            drive(inst, 1'b0, dir, n, press);
            return;
        end
        model_pos[inst] = build_trace((inst == 0) ? 0 : BN1, dir, int'(n), press, model_pos[inst]);
        @(negedge clk);
        if (!hold) drive(inst, 1'b0, dir, n, press);
        check_trace(inst, name);
    endtask

    task automatic test_reset;
        vec_t got, exp;
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 8'd0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_pos[0] = 8'h00;
        model_pos[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            exp = idle_vec(8'h00);
            got = observe(i);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset inst%0d: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp = idle_vec(8'h00);
            got = observe(i);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_release inst%0d: got %s, expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_right_click;
        int r0, l0;
        r0 = right_cnt[0]; l0 = left_cnt[0];
        run_cmd(0, 1'b0, 8'd1, 1'b0, 1'b0, "right_1");
        vectors++;
        if (right_cnt[0] - r0 !== 1 || left_cnt[0] - l0 !== 0) begin
            miscompares++;
            $display("FAIL right_1 decode: right=%0d left=%0d, expected right=1 left=0",
                     right_cnt[0] - r0, left_cnt[0] - l0);
        end
    endtask

    task automatic test_left_clicks;
        int r0, l0;
        r0 = right_cnt[0]; l0 = left_cnt[0];
        run_cmd(0, 1'b1, 8'd3, 1'b0, 1'b0, "left_3");
        vectors++;
        if (pos0 !== 8'hFD) begin
            miscompares++;
            $display("FAIL left_3 position: got %h, expected fd", pos0);
        end
        vectors++;
        if (right_cnt[0] - r0 !== 0 || left_cnt[0] - l0 !== 3) begin
            miscompares++;
            $display("FAIL left_3 decode: right=%0d left=%0d, expected right=0 left=3",
                     right_cnt[0] - r0, left_cnt[0] - l0);
        end
    endtask

    task automatic test_null_cmd;
        run_cmd(0, 1'b0, 8'd0, 1'b0, 1'b0, "null_cmd");
    endtask

    task automatic test_press;
        run_cmd(0, 1'b0, 8'd0, 1'b1, 1'b0, "press_only");
        vectors++;
        if (pos0 !== 8'hFD) begin
            miscompares++;
            $display("FAIL press_only position: got %h, expected fd", pos0);
        end
    endtask

    task automatic test_back_to_back;
        int r0, l0;
        r0 = right_cnt[0]; l0 = left_cnt[0];
        run_cmd(0, 1'b0, 8'd2, 1'b0, 1'b1, "b2b_right_2");
        vectors++;
        if (pos0 !== 8'hFF) begin
            miscompares++;
            $display("FAIL b2b position before wrap: got %h, expected ff", pos0);
        end
        run_cmd(0, 1'b0, 8'd1, 1'b0, 1'b1, "b2b_wrap");
        vectors++;
        if (pos0 !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b wrap position: got %h, expected 00", pos0);
        end
        run_cmd(0, 1'b0, 8'd1, 1'b1, 1'b0, "b2b_click_press");
        vectors++;
        if (right_cnt[0] - r0 !== 4 || left_cnt[0] - l0 !== 0) begin
            miscompares++;
            $display("FAIL b2b decode: right=%0d left=%0d, expected right=4 left=0",
                     right_cnt[0] - r0, left_cnt[0] - l0);
        end
    endtask

    task automatic test_bounce;
        int r0, l0;
        r0 = right_cnt[1]; l0 = left_cnt[1];
        run_cmd(1, 1'b0, 8'd1, 1'b0, 1'b0, "bounce_right");
        vectors++;
        if (right_cnt[1] - r0 !== 1 || left_cnt[1] - l0 !== 0) begin
            miscompares++;
            $display("FAIL bounce decode: right=%0d left=%0d, expected right=1 left=0",
                     right_cnt[1] - r0, left_cnt[1] - l0);
        end
    endtask

    task automatic test_reset_mid;
        vec_t got, exp;
        int   guard;
        drive(0, 1'b1, 1'b0, 8'd1, 1'b0);
        guard = 0;
        while (!(rot_a[0] === 1'b0 && rot_b[0] === 1'b0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL reset_mid never reached 00: A=%b B=%b", rot_a[0], rot_b[0]);
        end
        reset = 1'b0;
        #1;
        model_pos[0] = 8'h00;
        model_pos[1] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            exp = idle_vec(8'h00);
            got = observe(0);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid hold %0d: got %s, expected %s", k, fmt(got), fmt(exp));
            end
            @(negedge clk);
        end
        reset = 1'b1;
        model_pos[0] = build_trace(0, 1'b0, 1, 1'b0, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'd1, 1'b0);
        check_trace(0, "reset_mid_reaccept");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_right_click();
        test_reset();
        test_left_clicks();
        test_null_cmd();
        test_press();
        test_back_to_back();
        test_bounce();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
